// File: rtl/ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module      : ifu_fetch
// Description : Instruction fetch stage for the single-issue RV64 core.
//               Owns the PC and issues one instruction-memory request at a
//               time. It holds each returned instruction for decode and then
//               computes the next PC from the decoder's branch code.
// Ports       :
//   clk, rst              clock / synchronous active-high reset
//   imem_req_*            request channel (valid/ready, address = pc)
//   imem_resp_*           response channel (valid only, honoured in WAIT)
//   inst_valid/ready      decode handshake; inst, inst_pc, opcode/func3/func7
//   branch, imm, rs1_val  next-PC controls, sampled on an inst fire
//   fetch_fault           sticky misaligned-PC fault (terminal until reset)
//   fetch_count           number of instructions handed to decode (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module ifu_fetch #(
  parameter int          ADDR_W   = 64,
  parameter logic [63:0] RESET_PC = 64'h8000_0000,
  parameter int          INST_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [INST_W-1:0] imem_resp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [6:0]        opcode,
  output logic [2:0]        func3,
  output logic [6:0]        func7,
  input  logic [2:0]        branch,
  input  logic [ADDR_W-1:0] imm,
  input  logic [ADDR_W-1:0] rs1_val,
  output logic              fetch_fault,
  output logic [63:0]       fetch_count
);

  localparam logic [1:0] S_REQ   = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_FAULT = 2'd3;

  localparam logic [ADDR_W-1:0] c_pc_step  = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] c_lsb_mask = ~(ADDR_W'(1));

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [INST_W-1:0] r_inst;
  logic [ADDR_W-1:0] r_inst_pc;
  logic [63:0]       r_count;

  logic              w_misaligned;
  logic              w_req_valid;
  logic              w_inst_valid;
  logic              w_fire;
  logic [ADDR_W-1:0] w_next_pc;

  assign w_misaligned = (r_pc[1:0] != 2'b00);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_REQ;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_REQ: begin
        // A misaligned PC never reaches memory; it traps straight to FAULT.
        if (w_misaligned)        w_state_nxt = S_FAULT;
        else if (imem_req_ready) w_state_nxt = S_WAIT;
      end
      S_WAIT:  if (imem_resp_valid) w_state_nxt = S_HOLD;
      S_HOLD:  if (inst_ready)      w_state_nxt = S_REQ;
      default: w_state_nxt = S_FAULT;
    endcase
  end

  // Output logic
  always_comb begin
    w_req_valid  = 1'b0;
    w_inst_valid = 1'b0;
    case (r_state)
      S_REQ:   w_req_valid  = ~w_misaligned;
      S_HOLD:  w_inst_valid = 1'b1;
      default: begin
        w_req_valid  = 1'b0;
        w_inst_valid = 1'b0;
      end
    endcase
  end

  // Handshakes are masked while reset is held so nothing leaks out during the
  // reset cycle(s), whatever the state register currently holds.
  assign imem_req_valid = w_req_valid  & ~rst;
  assign inst_valid     = w_inst_valid & ~rst;
  assign w_fire         = w_inst_valid & inst_ready;

  // Next PC; all sums wrap modulo 2^ADDR_W.
  always_comb begin
    case (branch)
      3'd1:    w_next_pc = r_inst_pc + imm;
      3'd2:    w_next_pc = (rs1_val + imm) & c_lsb_mask;
      default: w_next_pc = r_inst_pc + c_pc_step;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc      <= RESET_PC[ADDR_W-1:0];
      r_inst    <= '0;
      r_inst_pc <= '0;
      r_count   <= '0;
    end else begin
      // Responses are only honoured in WAIT; stale ones elsewhere are dropped.
      if (r_state == S_WAIT && imem_resp_valid) begin
        r_inst    <= imem_resp_data;
        r_inst_pc <= r_pc;
      end
      if (w_fire) begin
        r_pc    <= w_next_pc;
        r_count <= r_count + 64'd1;
      end
    end
  end

  assign imem_req_addr = r_pc;
  assign inst          = r_inst;
  assign inst_pc       = r_inst_pc;
  assign opcode        = r_inst[6:0];
  assign func3         = r_inst[14:12];
  assign func7         = r_inst[31:25];
  assign fetch_fault   = (r_state == S_FAULT);
  assign fetch_count   = r_count;

endmodule
`default_nettype wire
